// File: rtl/xor_share_arbiter_if.sv
// Request/grant/result bundle between requesting engines and xor_share_arbiter.
// XOR_SHARE_ARBITER_STATS_EN adds the op_count statistics output.
interface xor_share_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  res_valid;
    logic [IDW-1:0]        res_id;
    logic [WIDTH-1:0]      result;
`ifdef XOR_SHARE_ARBITER_STATS_EN
    logic [15:0]           op_count;

    modport master (output req, a_in, b_in,
                    input  gnt, busy, res_valid, res_id, result, op_count);
    modport slave  (input  req, a_in, b_in,
                    output gnt, busy, res_valid, res_id, result, op_count);
`else
    modport master (output req, a_in, b_in,
                    input  gnt, busy, res_valid, res_id, result);
    modport slave  (input  req, a_in, b_in,
                    output gnt, busy, res_valid, res_id, result);
`endif
endinterface

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit XOR slice between NREQ requesters.
// Define XOR_SHARE_ARBITER_STATS_EN to add the op_count result counter.
module xor_share_arbiter #(
    parameter int  WIDTH = 16,
    parameter int  NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    xor_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [NREQ-1:0]  gnt_r;
    logic             busy_r;
    logic             res_valid_r;
    logic [IDW-1:0]   res_id_r;
    logic [IDW-1:0]   id_r;
    logic [IDW-1:0]   ptr_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] a_lat_r;
    logic [WIDTH-1:0] b_lat_r;

    logic [IDW-1:0]   ptr_eff_s;
    logic [IDW-1:0]   win_s;
    logic [IDW:0]     idx_s;
    logic             found_s;
    logic [WIDTH-1:0] a_sel_s;
    logic [WIDTH-1:0] b_sel_s;
    logic [WIDTH-1:0] xor_s;

    // Round-robin winner: first asserted req scanning upward from ptr, wrapping at NREQ
    always_comb begin
        ptr_eff_s = ({1'b0, ptr_r} < (IDW+1)'(NREQ)) ? ptr_r : '0;
        win_s     = '0;
        found_s   = 1'b0;
        idx_s     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = {1'b0, ptr_eff_s} + (IDW+1)'(k);
            if (idx_s >= (IDW+1)'(NREQ)) begin
                idx_s = idx_s - (IDW+1)'(NREQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && bus.req[idx_s[IDW-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Operand slice selection for the winning requester
    always_comb begin
        a_sel_s = '0;
        b_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_s == IDW'(i)) begin
                a_sel_s = bus.a_in[i*WIDTH +: WIDTH];
                b_sel_s = bus.b_in[i*WIDTH +: WIDTH];
            end else begin
                a_sel_s = a_sel_s;
                b_sel_s = b_sel_s;
            end
        end
    end

    // The single shared XOR datapath
    for (genvar g = 0; g < WIDTH; g++) begin : g_xor
        assign xor_s[g] = a_lat_r[g] ^ b_lat_r[g];
    end

    // Sequencer FSM: IDLE -> EXEC -> DONE -> IDLE with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            gnt_r       <= '0;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_id_r    <= '0;
            id_r        <= '0;
            ptr_r       <= '0;
            result_r    <= '0;
            a_lat_r     <= '0;
            b_lat_r     <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    res_valid_r <= 1'b0;
                    if (found_s) begin
                        a_lat_r <= a_sel_s;
                        b_lat_r <= b_sel_s;
                        gnt_r   <= NREQ'(1) << win_s;
                        id_r    <= win_s;
                        busy_r  <= 1'b1;
                        state_r <= S_EXEC;
                    end else begin
                        gnt_r   <= '0;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    result_r    <= xor_s;
                    res_id_r    <= id_r;
                    res_valid_r <= 1'b1;
                    gnt_r       <= '0;
                    state_r     <= S_DONE;
                end
                S_DONE: begin
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    ptr_r       <= (id_r == IDW'(NREQ-1)) ? '0 : id_r + IDW'(1);
                    state_r     <= S_IDLE;
                end
                default: begin
                    gnt_r       <= '0;
                    busy_r      <= 1'b0;
                    res_valid_r <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef XOR_SHARE_ARBITER_STATS_EN
    logic [15:0] op_count_r;

    // Count delivered results; wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_r <= 16'h0000;
        end else if (res_valid_r) begin
            op_count_r <= op_count_r + 16'h0001;
        end else begin
            op_count_r <= op_count_r;
        end
    end

    assign bus.op_count = op_count_r;
`endif

    assign bus.gnt       = gnt_r;
    assign bus.busy      = busy_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_id    = res_id_r;
    assign bus.result    = result_r;
endmodule

// File: doc/xor_share_arbiter.md
Name: xor_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit bitwise XOR datapath between NREQ requesters.
- Each requester raises a request with its operand pair. The block grants one requester, latches its operands, computes a XOR b into a registered result, and returns the result tagged with the requester ID.
- Sits between requesting engines and the single generate-based XOR slice, so that only one XOR instance is needed.

Parameters:
- WIDTH, 16, operand and result width in bits.
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NREQ), width of requester ID (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req  input  NREQ  per-requester request; bit i belongs to requester i
- a_in  input  NREQ*WIDTH  flattened operand A; requester i uses bits [i*WIDTH +: WIDTH]
- b_in  input  NREQ*WIDTH  flattened operand B, same packing as a_in
- gnt  output  NREQ  one-hot grant pulse, registered
- busy  output  1  high whenever state is not IDLE
- res_valid  output  1  one-cycle result strobe
- res_id  output  IDW  ID of requester that owns result
- result  output  WIDTH  registered a XOR b

Behaviour:
- Reset (async, active-high):
  - state=IDLE, gnt=0, busy=0, res_valid=0, res_id=0, result=0.
  - Operand registers cleared to 0.
  - Priority pointer ptr=0, so requester 0 has highest priority.
- FSM: IDLE -> EXEC -> DONE -> IDLE; fixed 3-cycle occupancy per operation.
- IDLE:
  - If req==0, remain in IDLE; all outputs hold their idle values.
  - Otherwise select winner w = first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping mod NREQ.
  - On that edge: register a_in/b_in slice w; gnt <= one-hot(w); id <= w; state <= EXEC.
- EXEC:
  - gnt is high for exactly this one cycle; busy=1.
  - On the exit edge: result <= a_lat ^ b_lat; res_id <= id; res_valid <= 1; gnt <= 0; state <= DONE.
- DONE:
  - res_valid=1 and result/res_id are valid for this one cycle.
  - On the exit edge: res_valid <= 0; ptr <= (w+1) mod NREQ; state <= IDLE.
  - result and res_id hold their values until the next operation overwrites them.
- Latency: request sampled at edge N -> gnt high in cycle N+1 -> res_valid high in cycle N+2. Peak throughput is one operation per 3 cycles.
- Handshake:
  - A requester holds req and its operands stable until it sees its gnt bit.
  - Operands are captured at the IDLE edge, so they may change once gnt is seen.
  - A req bit still high when the FSM returns to IDLE counts as a new request.
- Requests arriving while busy=1 are ignored, not queued; they are sampled at the next IDLE.
- Simultaneous requests: only the winner is served; the others wait. The pointer rotation guarantees every continuously-asserting requester is served within NREQ operations.
- Arithmetic: pure bitwise XOR, no carry, width-exact.
- Reset mid-operation (EXEC or DONE):
  - Immediate return to IDLE with all reset values.
  - The in-flight operation is dropped with no res_valid.
  - ptr returns to 0.
- An out-of-range ptr cannot occur; if one is encountered, treat it as 0.

Optional Feature:
- Macro: XOR_SHARE_ARBITER_STATS_EN.
- Defined:
  - Adds output op_count [15:0], reset to 0.
  - Increments by 1 on every cycle where res_valid=1; wraps from 16'hFFFF to 0.
  - Cleared by rst.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Single request: req=4'b0001, a0=16'haaaa, b0=16'h00ff. Required: gnt=4'b0001 one cycle later, then res_valid=1, result=16'haa55, res_id=0. busy=1 for 2 cycles.
- Round-robin: req=4'b1111 held high, operand pairs:
  - req0: 16'h0f0f, 16'h3333
  - req1: 16'h9ab0, 16'h12ff
  - req2: 16'hffff, 16'h0000
  - req3: 16'h1234, 16'h1234
  - Required grant order 0,1,2,3,0; results in order 16'h3c3c, 16'h884f, 16'hffff, 16'h0000.
- Pointer wrap: serve req3 alone, then raise req=4'b1001. Required: next grant goes to requester 0, because ptr wrapped to 0.
- Busy ignore: raise req1 during EXEC of a req2 operation. Required: no gnt to requester 1 until FSM returns to IDLE; gnt=4'b0010 exactly 3 cycles after the original grant edge.
- Reset mid-operation: assert rst during the EXEC cycle. Required: gnt, res_valid, busy and result all 0 immediately, and no res_valid pulse follows. After release, req=4'b0100 is served normally.
- With XOR_SHARE_ARBITER_STATS_EN defined: 5 back-to-back operations -> op_count=5. Preload by running 65536 operations -> op_count wraps to 0.
